// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 memory responder.
// Holds bus widths, the wait-counter width, the responder FSM state encoding,
// the latched operation encoding and a helper that classifies a request.
package mu0_pkg;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 16;
   // Wide enough for WAIT_CYCLES-1 with WAIT_CYCLES in 0..7.
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StDone
   } state_e;

   typedef enum logic [1:0] {
      OpRd,
      OpWr,
      OpBad
   } op_e;

   // Classify a request seen in IDLE. Only meaningful when rd or wr is high.
   // A simultaneous rd+wr, or a write into the protected region, becomes OpBad.
   function automatic op_e decode_op(logic rd, logic wr, logic wp_hit);
      if (rd && wr) begin
         return OpBad;
      end else if (wr) begin
         return wp_hit ? OpBad : OpWr;
      end else begin
         return OpRd;
      end
   endfunction

endpackage

// File: rtl/mu0_wait_counter.sv
// Wait-state down-counter for the MU0 memory responder.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset, clears the count
//   load  - load 'value' into the counter at the next edge
//   value - count to load
//   zero  - high while the count is zero
// Counts down by one per edge while non-zero and not loading.
module mu0_wait_counter
   import mu0_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = value;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/mu0_mem_responder.sv
// MU0 memory responder: 4096 x 16 word memory behind a rd/wr request
// interface with a configurable number of wait states.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset (memory contents are kept)
//   addr  - word address
//   wdata - write data
//   rd    - read request
//   wr    - write request
//   rdata - registered read data, held until the next completed read
//   ready - one-cycle completion strobe
//   err   - one-cycle error strobe, coincident with ready
// Parameters:
//   WAIT_CYCLES - wait states between acceptance and completion (0..7)
//   WP_BASE     - lowest write-protected address
// Configuration macro:
//   MU0_MEM_WP_EN - when defined, writes to addr >= WP_BASE are refused with err.
module mu0_mem_responder
   import mu0_pkg::*;
#(
   parameter int unsigned        WAIT_CYCLES = 1,
   parameter logic [ADDR_W-1:0]  WP_BASE     = 12'hF00
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rd,
   input  logic              wr,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              err
);

   localparam logic [CNT_W-1:0] WaitLoad =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic wp_hit;
   logic cnt_load;
   logic cnt_zero;
   op_e  req_op;

`ifdef MU0_MEM_WP_EN
   assign wp_hit = (addr >= WP_BASE);
`else
   assign wp_hit = 1'b0;
`endif

   assign req_op = decode_op(rd, wr, wp_hit);

   mu0_wait_counter u_wait_counter (
      .clk   (clk),
      .reset (reset),
      .load  (cnt_load),
      .value (WaitLoad),
      .zero  (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      cnt_load = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rd || wr) begin
               op_d    = req_op;
               addr_d  = addr;
               wdata_d = wdata;
               if (WAIT_CYCLES > 0) begin
                  state_d  = StWait;
                  cnt_load = 1'b1;
               end else begin
                  // No wait states: read data must land on the accepting edge,
                  // so it comes straight from the live address.
                  state_d = StDone;
                  if (req_op == OpRd) begin
                     rdata_d = mem[addr];
                  end
               end
            end
         end
         StWait: begin
            if (cnt_zero) begin
               state_d = StDone;
               if (op_q == OpRd) begin
                  rdata_d = mem[addr_q];
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         op_q    <= OpRd;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Writes commit on the edge leaving DONE; a reset on that edge aborts them.
   always_ff @(posedge clk) begin
      if (!reset && (state_q == StDone) && (op_q == OpWr)) begin
         mem[addr_q] <= wdata_q;
      end
   end

   assign ready = (state_q == StDone);
   assign err   = (state_q == StDone) && (op_q == OpBad);
   assign rdata = rdata_q;

endmodule

// File: tb/tb_mu0_mem_responder.sv
// Bench for mu0_mem_responder: two instances (WAIT_CYCLES=1 and 0) driven by
// directed and random requests, checked every cycle against a transaction
// model, plus literal checks on the documented scenarios.
module tb_mu0_mem_responder;

   localparam int unsigned WaitA = 1;
   localparam int unsigned WaitB = 0;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] addr  [2];
   logic [15:0] wdata [2];
   logic        rd    [2];
   logic        wr    [2];
   logic [15:0] rdata [2];
   logic        ready [2];
   logic        err   [2];

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   // Transaction-level model state, one set per instance.
   logic [15:0] m_mem   [2][4096];
   bit          m_known [2][4096];
   bit          m_busy  [2];
   bit          m_done  [2];
   int          m_left  [2];
   logic [11:0] m_a     [2];
   logic [15:0] m_d     [2];
   bit          m_rd    [2];
   bit          m_wr    [2];
   bit          m_bad   [2];
   logic        exp_ready [2];
   logic        exp_err   [2];
   logic [15:0] exp_rdata [2];
   bit          exp_known [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mu0_mem_responder #(
         .WAIT_CYCLES ((g == 0) ? WaitA : WaitB),
         .WP_BASE     (12'hF00)
      ) u_dut (
         .clk   (clk),
         .reset (reset),
         .addr  (addr[g]),
         .wdata (wdata[g]),
         .rd    (rd[g]),
         .wr    (wr[g]),
         .rdata (rdata[g]),
         .ready (ready[g]),
         .err   (err[g])
      );

      always @(posedge clk) model_step(g);
   end

   function automatic int wait_of(int i);
      return (i == 0) ? int'(WaitA) : int'(WaitB);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   task automatic enter_done(int i);
      m_done[i]    = 1'b1;
      exp_ready[i] = 1'b1;
      exp_err[i]   = m_bad[i];
      if (m_rd[i] && !m_wr[i]) begin
         exp_rdata[i] = m_mem[i][m_a[i]];
         exp_known[i] = m_known[i][m_a[i]];
      end
   endtask

   // Completion happens WAIT edges after acceptance; writes land when the
   // completion cycle ends; reset aborts anything in flight.
   task automatic model_step(int i);
      bit wp;
      if (reset) begin
         m_busy[i]    = 1'b0;
         m_done[i]    = 1'b0;
         exp_ready[i] = 1'b0;
         exp_err[i]   = 1'b0;
         exp_rdata[i] = 16'h0000;
         exp_known[i] = 1'b1;
      end else if (m_done[i]) begin
         if (m_wr[i] && !m_rd[i] && !m_bad[i]) begin
            m_mem[i][m_a[i]]   = m_d[i];
            m_known[i][m_a[i]] = 1'b1;
         end
         m_done[i]    = 1'b0;
         m_busy[i]    = 1'b0;
         exp_ready[i] = 1'b0;
         exp_err[i]   = 1'b0;
      end else if (m_busy[i]) begin
         m_left[i]--;
         if (m_left[i] == 0) enter_done(i);
      end else if (rd[i] || wr[i]) begin
`ifdef MU0_MEM_WP_EN
         wp = wr[i] && !rd[i] && (addr[i] >= 12'hF00);
`else
         wp = 1'b0;
`endif
         m_a[i]    = addr[i];
         m_d[i]    = wdata[i];
         m_rd[i]   = rd[i];
         m_wr[i]   = wr[i];
         m_bad[i]  = (rd[i] && wr[i]) || wp;
         m_busy[i] = 1'b1;
         m_left[i] = wait_of(i);
         if (m_left[i] == 0) enter_done(i);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            chk((i == 0) ? "cyc_ready_a" : "cyc_ready_b", 32'(ready[i]), 32'(exp_ready[i]));
            chk((i == 0) ? "cyc_err_a" : "cyc_err_b", 32'(err[i]), 32'(exp_err[i]));
            if (exp_known[i]) begin
               chk((i == 0) ? "cyc_rdata_a" : "cyc_rdata_b", 32'(rdata[i]), 32'(exp_rdata[i]));
            end
         end
      end
   end

   // Issue one request, scramble the inputs while busy (including the DONE
   // cycle), wait for ready and report data, error and latency in cycles.
   task automatic req(input int i, input logic r, input logic w, input logic [11:0] a,
                      input logic [15:0] d, output logic [15:0] o_rdata,
                      output logic o_err, output int o_lat);
      int n;
      @(negedge clk);
      rd[i]    = r;
      wr[i]    = w;
      addr[i]  = a;
      wdata[i] = d;
      n = 0;
      @(negedge clk);
      rd[i]    = 1'($urandom);
      wr[i]    = 1'($urandom);
      addr[i]  = a ^ 12'h001;
      wdata[i] = 16'($urandom);
      while (!ready[i] && n < 20) begin
         @(negedge clk);
         rd[i]    = 1'($urandom);
         wr[i]    = 1'($urandom);
         wdata[i] = 16'($urandom);
         n++;
      end
      if (n >= 20) begin
         errors++;
         $display("FAIL ready_timeout actual=no_ready required=ready inst=%0d", i);
      end
      o_rdata = rdata[i];
      o_err   = err[i];
      o_lat   = n + 1;
      @(negedge clk);
      rd[i] = 1'b0;
      wr[i] = 1'b0;
   endtask

   function automatic logic [11:0] pick_addr();
      case ($urandom_range(0, 3))
         0, 1:    return 12'h100 + 12'($urandom_range(0, 7));
         2:       return 12'hF80 + 12'($urandom_range(0, 3));
         default: return 12'hE00 + 12'($urandom_range(0, 3));
      endcase
   endfunction

   initial begin
      logic [15:0] rv;
      logic        ev;
      int          lat;
      int          k;
      logic        r;
      logic        w;

      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      end
      @(posedge clk);
      @(negedge clk);
      started = 1'b1;
      chk("reset_ready", 32'(ready[0]), 32'd0);
      chk("reset_err", 32'(err[0]), 32'd0);
      chk("reset_rdata", 32'(rdata[0]), 32'h0000);
      reset = 1'b0;

      // Write then read back, WAIT_CYCLES=1.
      req(0, 1'b0, 1'b1, 12'h010, 16'hABCD, rv, ev, lat);
      chk("wr_latency", 32'(lat), 32'd2);
      chk("wr_err", 32'(ev), 32'd0);
      req(0, 1'b1, 1'b0, 12'h010, 16'h0000, rv, ev, lat);
      chk("rd_latency", 32'(lat), 32'd2);
      chk("rd_data_abcd", 32'(rv), 32'hABCD);
      chk("model_abcd", 32'(exp_rdata[0]), 32'hABCD);

      // Simultaneous rd+wr: error, no access, rdata held.
      req(0, 1'b0, 1'b1, 12'h020, 16'h5A5A, rv, ev, lat);
      req(0, 1'b1, 1'b1, 12'h020, 16'hFFFF, rv, ev, lat);
      chk("both_err", 32'(ev), 32'd1);
      chk("both_rdata_held", 32'(rv), 32'hABCD);
      req(0, 1'b1, 1'b0, 12'h020, 16'h0000, rv, ev, lat);
      chk("both_mem_kept", 32'(rv), 32'h5A5A);

      // Address changes during WAIT are ignored.
      req(0, 1'b0, 1'b1, 12'h040, 16'h7777, rv, ev, lat);
      req(0, 1'b0, 1'b1, 12'h041, 16'h1111, rv, ev, lat);
      req(0, 1'b1, 1'b0, 12'h040, 16'h0000, rv, ev, lat);
      chk("addr_change_ignored", 32'(rv), 32'h7777);

      // Reset during WAIT aborts the write.
      req(0, 1'b0, 1'b1, 12'h030, 16'hBEEF, rv, ev, lat);
      @(negedge clk);
      wr[0] = 1'b1; addr[0] = 12'h030; wdata[0] = 16'h1234;
      @(negedge clk);
      wr[0] = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("abort_ready", 32'(ready[0]), 32'd0);
      chk("abort_rdata", 32'(rdata[0]), 32'h0000);
      reset = 1'b0;
      req(0, 1'b1, 1'b0, 12'h030, 16'h0000, rv, ev, lat);
      chk("abort_mem_kept", 32'(rv), 32'hBEEF);

      // Write protection region.
      req(0, 1'b0, 1'b1, 12'hF80, 16'h5555, rv, ev, lat);
`ifdef MU0_MEM_WP_EN
      chk("wp_err", 32'(ev), 32'd1);
      req(0, 1'b1, 1'b0, 12'hF80, 16'h0000, rv, ev, lat);
      chk("wp_not_written", 32'(rv == 16'h5555), 32'd0);
`else
      chk("nowp_err", 32'(ev), 32'd0);
      req(0, 1'b1, 1'b0, 12'hF80, 16'h0000, rv, ev, lat);
      chk("nowp_written", 32'(rv), 32'h5555);
`endif
      req(0, 1'b0, 1'b1, 12'hE00, 16'h5555, rv, ev, lat);
      chk("low_wr_err", 32'(ev), 32'd0);
      req(0, 1'b1, 1'b0, 12'hE00, 16'h0000, rv, ev, lat);
      chk("low_written", 32'(rv), 32'h5555);

      // Zero wait states.
      req(1, 1'b0, 1'b1, 12'h010, 16'hC0DE, rv, ev, lat);
      chk("w0_wr_latency", 32'(lat), 32'd1);
      req(1, 1'b1, 1'b0, 12'h010, 16'h0000, rv, ev, lat);
      chk("w0_rd_latency", 32'(lat), 32'd1);
      chk("w0_rd_err", 32'(ev), 32'd0);
      chk("w0_rd_data", 32'(rv), 32'hC0DE);

      // Random traffic, checked cycle by cycle against the model.
      for (int it = 0; it < 300; it++) begin
         k = $urandom_range(0, 9);
         r = (k < 5) || (k == 9);
         w = (k >= 5);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         req(int'($urandom_range(0, 1)), r, w, pick_addr(), 16'($urandom), rv, ev, lat);
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
